// File: rtl/symbol_sampler.sv
// Multi-channel symbol-rate sampler.
// Decimates an oversampled stream by capturing one sample per symbol at a
// programmable phase, and queues captures in a small first-word-fall-through
// buffer drained with a valid/ready handshake. Captures that find the buffer
// full (with no simultaneous pop) are dropped and raise a sticky overflow flag.
module symbol_sampler #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        osr_m1,
    input  logic [CNT_W-1:0]        phase,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    output logic                    busy,
    output logic                    overflow,
    output logic [15:0]             sym_count
);

    localparam int DW = NUM_CH * WIDTH;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] osr_reg;
    logic [CNT_W-1:0] phase_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             overflow_reg;
    logic [15:0]      sym_count_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [DW-1:0]    mem_reg [DEPTH];

    logic             armed;
    logic             accept_start;
    logic             strobe;
    logic             buf_empty;
    logic             buf_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] phase_clamped;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // Decode of control strobes and buffer status from the current registers.
    always_comb begin
        armed         = (state_reg != IDLE);
        accept_start  = start && !stop && (state_reg == IDLE);
        strobe        = in_valid && armed && (cnt_reg == phase_reg);
        buf_empty     = (wr_ptr_reg == rd_ptr_reg);
        buf_full      = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                        (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
        pop           = !buf_empty && out_ready;
        // A full buffer still takes the capture when the head leaves this cycle.
        push          = strobe && (!buf_full || pop);
        drop          = strobe && !push;
        // A capture phase beyond the symbol period would never match; clamp it.
        phase_clamped = (phase > osr_m1) ? osr_m1 : phase;
        wr_idx        = wr_ptr_reg[AW-1:0];
        rd_idx        = rd_ptr_reg[AW-1:0];
    end

    // Sampler FSM, configuration latch and oversampling phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            osr_reg   <= '0;
            phase_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            // Counter only moves on real input samples while armed.
            if (in_valid && armed) begin
                cnt_reg <= (cnt_reg == osr_reg) ? '0 : cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (accept_start) begin
                        state_reg <= ALIGN;
                        busy_reg  <= 1'b1;
                        osr_reg   <= osr_m1;
                        phase_reg <= phase_clamped;
                        cnt_reg   <= '0;
                    end
                end
                ALIGN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (strobe) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag and accepted-capture counter, both cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            sym_count_reg <= '0;
        end else if (accept_start) begin
            overflow_reg  <= 1'b0;
            sym_count_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                sym_count_reg <= sym_count_reg + 16'd1;
            end
        end
    end

    // Buffer pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Buffer storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_idx] <= data_in;
        end
    end

    assign out_valid = !buf_empty;
    assign data_out  = mem_reg[rd_idx];
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;
    assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_symbol_sampler.sv
// Bench for symbol_sampler: directed control scenarios mixed with randomized
// data and handshakes, compared every cycle against a behavioural model that
// keeps the expected buffer contents as a queue.
module tb_symbol_sampler;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int DW     = NUM_CH * WIDTH;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] osr_m1;
    logic [CNT_W-1:0] phase;
    logic             in_valid;
    logic [DW-1:0]    data_in;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    data_out;
    logic             busy;
    logic             overflow;
    logic [15:0]      sym_count;

    symbol_sampler #(
        .WIDTH (WIDTH),
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .osr_m1   (osr_m1),
        .phase    (phase),
        .in_valid (in_valid),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy),
        .overflow (overflow),
        .sym_count(sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: armed flag, position within the symbol, config,
    // expected buffer contents, overflow flag and accepted-capture count.
    bit            m_armed;
    int            m_pos;
    int            m_osr;
    int            m_ph;
    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("data_out", data_out, m_q[0]);
        chk("busy", 32'(busy), 32'(m_armed));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("sym_count", 32'(sym_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_armed = 0; m_pos = 0; m_osr = 0; m_ph = 0;
        m_q.delete(); m_ovf = 0; m_cnt = 0;
    endtask

    // One clock: predict from the inputs now applied, clock, then compare.
    task automatic cycle();
        bit pop, cap, full;
        pop  = (m_q.size() != 0) && out_ready;
        cap  = in_valid && m_armed && (m_pos == m_ph);
        full = (m_q.size() == DEPTH);
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (!full || pop) begin
                m_q.push_back(data_in);
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_ovf = 1;
            end
        end
        if (in_valid && m_armed) m_pos = (m_pos == m_osr) ? 0 : m_pos + 1;
        if (stop) begin
            m_armed = 0;
        end else if (start && !m_armed) begin
            m_armed = 1;
            m_osr   = int'(osr_m1);
            m_ph    = (int'(phase) < int'(osr_m1)) ? int'(phase) : int'(osr_m1);
            m_pos   = 0;
            m_cnt   = 0;
            m_ovf   = 0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check_outputs();
    endtask

    task automatic do_start(input int o, input int p);
        osr_m1 = CNT_W'(o);
        phase  = CNT_W'(p);
        start  = 1'b1;
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic do_stop();
        stop = 1'b1;
        in_valid = 1'b0;
        cycle();
    endtask

    logic [DW-1:0] ramp;

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; osr_m1 = 0; phase = 0;
        in_valid = 0; data_in = '0; out_ready = 0;
        model_reset();
        #2;
        chk("reset_data_out", data_out, 32'h0);
        check_outputs();
        #10 rst_n = 1'b1;
        @(negedge clk);
        cycle();

        // Basic capture: osr 4, phase 2, ramp data -> 2, 6, 10, ...
        out_ready = 1'b1;
        do_start(3, 2);
        ramp = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = ramp;
            cycle();
            if (i == 2) chk("first_capture", data_out, 32'd2);
            ramp = ramp + 1'b1;
        end
        chk("basic_count", 32'(sym_count), 32'd5);
        do_stop();

        // osr_m1 = 0 with phase clamp: every valid sample captured.
        do_start(0, 5);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = DW'($urandom);
            cycle();
        end
        do_stop();
        // osr 2, phase 3 clamped to 1: odd slots only.
        do_start(1, 3);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = DW'(i);
            cycle();
        end
        do_stop();

        // Gapped input: counter frozen while in_valid low.
        do_start(3, 0);
        for (int i = 0; i < 40; i++) begin
            in_valid = (i % 2 == 0);
            data_in  = DW'($urandom);
            cycle();
        end
        do_stop();

        // Backpressure: six symbols into a 4-deep buffer.
        out_ready = 1'b0;
        do_start(1, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_in = DW'($urandom);
            cycle();
        end
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_count", 32'(sym_count), 32'd4);
        do_stop();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        do_start(2, 1);
        chk("restart_ovf", 32'(overflow), 32'd0);
        do_stop();

        // Full buffer with a pop on the capture cycle.
        do_start(1, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = DW'($urandom);
            cycle();
        end
        out_ready = 1'b1;
        data_in = DW'($urandom);
        cycle();
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        chk("full_pop_count", 32'(sym_count), 32'd5);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            cycle();
        end
        do_stop();

        // Control edge cases: start with stop from IDLE stays idle.
        start = 1'b1; stop = 1'b1; osr_m1 = 4'd2; phase = 4'd0;
        cycle();
        chk("start_stop_idle", 32'(busy), 32'd0);
        // Start during RUN is ignored (model keeps old config).
        do_start(3, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = DW'($urandom);
            if (i == 3) begin
                start = 1'b1; osr_m1 = 4'd0; phase = 4'd0;
            end
            cycle();
        end

        // Randomized traffic with random handshakes.
        for (int i = 0; i < 150; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            data_in   = DW'($urandom);
            cycle();
        end
        do_stop();

        // Asynchronous reset mid-run with 3 entries buffered.
        out_ready = 1'b0;
        do_start(0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = DW'($urandom);
            cycle();
        end
        chk("pre_reset_count", 32'(sym_count), 32'd3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(sym_count), 32'd0);
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/symbol_sampler.md
Name: symbol_sampler

Overview:
Multi-channel symbol-rate sampler for the QAM receiver. It takes an oversampled per-channel stream (I and Q by default) and captures one sample per symbol at a programmable phase within the oversampling period. Captured samples go into a small first-word-fall-through buffer, read out with a valid/ready handshake toward the demapper. This block replaces the single-register start/ready sampler and adds decimation, phase selection, buffering, backpressure and overflow detection.

Parameters:
WIDTH, 16, bits per channel sample
NUM_CH, 2, number of channels carried side by side in the data buses (channel k at bits [k*WIDTH +: WIDTH])
CNT_W, 4, width of the oversampling counter; supports up to 2^CNT_W samples per symbol
DEPTH, 4, output buffer entries; must be a power of 2 and at least 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms the sampler and latches osr_m1/phase
stop  input  1  one-cycle pulse; disarms the sampler
osr_m1  input  CNT_W  oversampling ratio minus one; sampled only on an accepted start
phase  input  CNT_W  capture phase within the symbol period; sampled only on an accepted start
in_valid  input  1  data_in carries a new oversampled sample this cycle
data_in  input  NUM_CH*WIDTH  packed channel samples
out_valid  output  1  buffer not empty; data_out holds the oldest sample
out_ready  input  1  consumer accepts data_out this cycle
data_out  output  NUM_CH*WIDTH  buffer head, first-word-fall-through
busy  output  1  sampler armed (state ALIGN or RUN)
overflow  output  1  sticky flag: a capture was dropped because the buffer was full
sym_count  output  16  number of samples pushed since the last accepted start

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - state = IDLE; phase counter = 0; config registers = 0.
  - Buffer empty, so out_valid = 0 and data_out = 0.
  - busy = 0, overflow = 0, sym_count = 0.
- States:
  - IDLE: no captures.
  - ALIGN: armed, waiting for the first capture.
  - RUN: capturing once per symbol.
- Transitions:
  - IDLE -> ALIGN on start && !stop.
  - ALIGN -> RUN on the first capture strobe.
  - ALIGN/RUN -> IDLE on stop.
  - stop has priority over start in the same cycle.
  - start outside IDLE is ignored; it does not re-latch config or clear counters.
- Accepted start: in the same edge,
  - latch osr_m1 into osr_l;
  - latch phase_l = min(phase, osr_m1);
  - clear the phase counter, sym_count and overflow.
  - Buffer contents are preserved.
- Phase counter:
  - Advances only on in_valid in ALIGN/RUN.
  - Wraps from osr_l to 0; holds when in_valid is low.
  - With osr_l = 0, every valid input is a capture.
- Capture strobe: in_valid && state != IDLE && cnt == phase_l, where cnt is the counter value before the increment.
- Push on strobe:
  - Accepted if the buffer is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the sample is dropped, overflow sets and stays set until the next accepted start or reset, and sym_count does not increment.
- sym_count: +1 per accepted push; wraps from 0xFFFF to 0.
- Latency: data_in captured at edge N appears on data_out with out_valid = 1 after edge N when the buffer was empty (one cycle).
- Buffer:
  - Pop on out_valid && out_ready.
  - Pointers are log2(DEPTH)+1 bits; full = MSBs differ and the rest are equal.
  - data_out is driven from the head entry; its value is don't-care while out_valid = 0.
  - Simultaneous push and pop at empty is not possible, since out_valid = 0; the push just occurs.
- Stop mid-symbol: the counter freezes at its current value, and the buffer remains drainable in IDLE.
- Reset mid-operation: everything returns to reset values immediately and buffered samples are lost.
- busy = (state != IDLE), registered.

Test Plan:
1. Basic capture: start with osr_m1=3, phase=2; in_valid constant 1; data_in = count 0,1,2,... from the cycle after start; out_ready=1 -> data_out = 2, 6, 10, 14...; out_valid one cycle after each capture; busy=1; sym_count increments by 1 per symbol.
2. Phase clamp and osr_m1=0: start with osr_m1=0, phase=5 -> every valid input is captured, output equals input delayed one cycle. Then stop, and start with osr_m1=1, phase=3 -> captures on odd counter slots only.
3. Gapped input: in_valid toggling 1,0,1,0 with osr_m1=3, phase=0 -> one capture per 4 valid samples; the counter is frozen during gaps.
4. Backpressure and overflow: DEPTH=4, out_ready=0, six symbols -> first 4 samples held; overflow=1 at the 5th strobe; sym_count=4. Releasing out_ready drains exactly the 4 samples in order. A new start clears overflow and sym_count but keeps no stale data.
5. Full with simultaneous pop: buffer full, out_ready=1 on a strobe cycle -> push accepted, overflow stays 0, order preserved.
6. Control edge cases:
   - start and stop in the same cycle from IDLE -> stays IDLE.
   - start during RUN -> ignored, config unchanged.
   - rst_n asserted mid-RUN with 3 entries buffered -> out_valid=0, busy=0, sym_count=0 immediately.
